// File: rtl/lcd_sequencer_if.sv
// LCD sequencer bus bundle: the 32-bit control word from the LSU and the
// HD44780-style pins and status returned by the sequencer.
// master = LSU/register side (drives the word), slave = sequencer.
interface lcd_sequencer_if;
    logic [31:0] i_lcd;       // [7:0] data, [8] rs, [9] request toggle, [30] backlight, [31] power
    logic [7:0]  o_lcd_data;  // LCD data bus, write-only
    logic        o_lcd_rs;    // register select
    logic        o_lcd_rw;    // always 0 (write)
    logic        o_lcd_en;    // enable strobe
    logic        o_lcd_on;    // registered display power
    logic        o_lcd_blon;  // registered backlight
    logic        o_busy;      // sequencer not idle
    logic        o_done;      // one-cycle transfer-complete pulse

    modport master (
        output i_lcd,
        input  o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en,
        input  o_lcd_on, o_lcd_blon, o_busy, o_done
    );

    modport slave (
        input  i_lcd,
        output o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en,
        output o_lcd_on, o_lcd_blon, o_busy, o_done
    );
endinterface

// File: rtl/lcd_sequencer.sv
// Turns the LSU LCD word (data/rs + request toggle) into timed HD44780 write cycles.
// Latency: accept->done = T_SETUP+T_PULSE+T_HOLD+T_wait+1 cycles; power/backlight 1 cycle.
// Backpressure: none on the bus; a toggle is a pending request until the engine is idle, o_busy reports it.
//
// Ports: i_clk (clock), i_reset (synchronous, active-low), bus (lcd_sequencer_if.slave):
//   i_lcd in; o_lcd_data/o_lcd_rs/o_lcd_rw/o_lcd_en pins; o_lcd_on/o_lcd_blon; o_busy/o_done status.
module lcd_sequencer #(
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 4,
    parameter int T_PULSE   = 12,
    parameter int T_HOLD    = 4,
    parameter int T_EXEC    = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  logic           i_clk,
    input  logic           i_reset,
    lcd_sequencer_if.slave bus
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_PULSE, T_HOLD)),
                                max2(T_EXEC, T_CLEAR));
    localparam int CW = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] C_POWERUP = CW'(T_POWERUP);
    localparam logic [CW-1:0] C_SETUP   = CW'(T_SETUP);
    localparam logic [CW-1:0] C_PULSE   = CW'(T_PULSE);
    localparam logic [CW-1:0] C_HOLD    = CW'(T_HOLD);
    localparam logic [CW-1:0] C_EXEC    = CW'(T_EXEC);
    localparam logic [CW-1:0] C_CLEAR   = CW'(T_CLEAR);
    localparam logic [CW-1:0] C_ONE     = CW'(1);

    localparam logic [2:0] S_POWERUP = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_PULSE   = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wait_len;
    logic          req_seen;
    logic [7:0]    data_q;
    logic          rs_q;
    logic          on_q;
    logic          blon_q;
    logic          done_q;

    logic          pending;
    logic          last;
    logic          long_cmd;
    logic          unused_bits;

    // A request is a toggle of bit 9 relative to the last accepted value, so
    // an even number of toggles while busy cancels out by construction.
    assign pending  = req_seen != bus.i_lcd[9];
    // Counter is loaded with the state length on entry; the value 1 marks the
    // final cycle of that state.
    assign last     = cnt == C_ONE;
    // Clear (0x01) and home (0x02) need the long execution wait.
    assign long_cmd = !bus.i_lcd[8] && (bus.i_lcd[7:0] == 8'h01 || bus.i_lcd[7:0] == 8'h02);
    assign unused_bits = ^bus.i_lcd[29:10];

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state    <= S_POWERUP;
            cnt      <= C_POWERUP;
            wait_len <= C_EXEC;
            req_seen <= 1'b0;
            data_q   <= 8'h00;
            rs_q     <= 1'b0;
            on_q     <= 1'b0;
            blon_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Power and backlight are pass-through registers, independent of
            // any transfer in flight.
            on_q   <= bus.i_lcd[31];
            blon_q <= bus.i_lcd[30];
            done_q <= 1'b0;

            case (state)
                S_POWERUP: begin
                    if (last) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - C_ONE;
                    end
                end
                S_IDLE: begin
                    if (pending) begin
                        data_q   <= bus.i_lcd[7:0];
                        rs_q     <= bus.i_lcd[8];
                        req_seen <= bus.i_lcd[9];
                        wait_len <= long_cmd ? C_CLEAR : C_EXEC;
                        state    <= S_SETUP;
                        cnt      <= C_SETUP;
                    end
                end
                S_SETUP: begin
                    if (last) begin
                        state <= S_PULSE;
                        cnt   <= C_PULSE;
                    end else begin
                        cnt <= cnt - C_ONE;
                    end
                end
                S_PULSE: begin
                    if (last) begin
                        state <= S_HOLD;
                        cnt   <= C_HOLD;
                    end else begin
                        cnt <= cnt - C_ONE;
                    end
                end
                S_HOLD: begin
                    if (last) begin
                        state <= S_WAIT;
                        cnt   <= wait_len;
                    end else begin
                        cnt <= cnt - C_ONE;
                    end
                end
                S_WAIT: begin
                    if (last) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - C_ONE;
                    end
                end
                default: begin
                    state <= S_POWERUP;
                    cnt   <= C_POWERUP;
                end
            endcase
        end
    end

    assign bus.o_lcd_data = data_q;
    assign bus.o_lcd_rs   = rs_q;
    assign bus.o_lcd_rw   = 1'b0;
    assign bus.o_lcd_en   = state == S_PULSE;
    assign bus.o_lcd_on   = on_q;
    assign bus.o_lcd_blon = blon_q;
    assign bus.o_busy     = state != S_IDLE;
    assign bus.o_done     = done_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
module tb_lcd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lcd_word = 32'h0;
    logic        toggle = 1'b0;

    lcd_sequencer_if lcd_if ();
    assign lcd_if.i_lcd = lcd_word;

    lcd_sequencer #(
        .T_POWERUP(10), .T_SETUP(2), .T_PULSE(3),
        .T_HOLD(2), .T_EXEC(5), .T_CLEAR(9)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (lcd_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         lat;   // acceptance cycle 0 to o_done cycle
    } exp_t;

    exp_t exp_q[$];
    exp_t vecs[7];

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor/scoreboard: times each transfer from the first busy cycle
    // (cycle 1 after acceptance) and compares against the queued record.
    bit prev_busy = 1'b1;
    bit active = 1'b0;
    int t = 0, en_first = 0, en_n = 0;
    always @(negedge clk) begin
        if (!mon_en) begin
            active = 1'b0;
        end else begin
            if (lcd_if.o_busy && !prev_busy) begin
                active = 1'b1; t = 1; en_first = 0; en_n = 0;
            end else if (active) begin
                t++;
            end
            if (active && lcd_if.o_lcd_en) begin
                en_n++;
                if (en_first == 0) en_first = t;
            end
            if (lcd_if.o_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_latency", t, e.lat);
                    check("en_first_cycle", en_first, 3);
                    check("en_length", en_n, 3);
                    check("lcd_data", lcd_if.o_lcd_data, e.data);
                    check("lcd_rs", lcd_if.o_lcd_rs, e.rs);
                    check("lcd_rw", lcd_if.o_lcd_rw, 0);
                end
                active = 1'b0;
            end
        end
        if (lcd_if.o_done) done_cnt++;
        prev_busy = lcd_if.o_busy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [7:0] d, input logic rs, input int lat);
        exp_t e;
        toggle = ~toggle;
        lcd_word[7:0] = d;
        lcd_word[8]   = rs;
        lcd_word[9]   = toggle;
        e.data = d; e.rs = rs; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int start;
        bit seen;
        start = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != start) begin seen = 1'b1; break; end
        end
        check("wait_done_timeout", seen, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit seen;
        seen = !lcd_if.o_busy;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = !lcd_if.o_busy;
        end
        check("wait_idle_timeout", seen, 1);
    endtask

    task automatic wait_en(input logic lvl);
        bit seen;
        seen = (lcd_if.o_lcd_en == lvl);
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            seen = (lcd_if.o_lcd_en == lvl);
        end
        check("wait_en_timeout", seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int d0;
        bit en_seen, done_seen;

        vecs[0] = '{8'h41, 1'b1, 13};   // data write
        vecs[1] = '{8'h01, 1'b0, 17};   // clear
        vecs[2] = '{8'h02, 1'b0, 17};   // home
        vecs[3] = '{8'h01, 1'b1, 13};   // 0x01 as data is not a clear
        vecs[4] = '{8'h38, 1'b0, 13};   // function set
        vecs[5] = '{8'h03, 1'b0, 13};   // just above home
        vecs[6] = '{8'hFF, 1'b1, 13};

        // Reset values
        for (int i = 0; i < 3; i++) tick();
        check("rst_busy", lcd_if.o_busy, 1);
        check("rst_en", lcd_if.o_lcd_en, 0);
        check("rst_done", lcd_if.o_done, 0);
        check("rst_data", lcd_if.o_lcd_data, 0);
        check("rst_rs", lcd_if.o_lcd_rs, 0);
        check("rst_rw", lcd_if.o_lcd_rw, 0);
        check("rst_on", lcd_if.o_lcd_on, 0);
        check("rst_blon", lcd_if.o_lcd_blon, 0);

        // Power-up wait
        rst_n = 1'b1;
        mon_en = 1'b1;
        n = 0; en_seen = 0; done_seen = 0;
        while (lcd_if.o_busy && n < 50) begin
            n++;
            tick();
            en_seen |= lcd_if.o_lcd_en;
            done_seen |= lcd_if.o_done;
        end
        check("powerup_cycles", n, 10);
        check("powerup_en", en_seen, 0);
        check("powerup_done", done_seen, 0);
        for (int i = 0; i < 5; i++) tick();
        check("idle_no_request", lcd_if.o_busy, 0);

        // Table of single transfers
        for (int i = 0; i < 7; i++) begin
            wait_idle(100);
            start_xfer(vecs[i].data, vecs[i].rs, vecs[i].lat);
            tick();
            check("accept_busy", lcd_if.o_busy, 1);
            check("accept_data", lcd_if.o_lcd_data, vecs[i].data);
            wait_done(100);
        end

        // Odd toggle while busy: second transfer accepted in the done cycle
        wait_idle(100);
        start_xfer(8'h48, 1'b1, 13);
        wait_en(1'b1);
        start_xfer(8'h01, 1'b0, 17);
        wait_done(100);
        check("b2b_done_busy", lcd_if.o_busy, 0);
        check("b2b_data_held", lcd_if.o_lcd_data, 8'h48);
        tick();
        check("b2b_busy_next", lcd_if.o_busy, 1);
        check("b2b_data_next", lcd_if.o_lcd_data, 8'h01);
        check("b2b_rs_next", lcd_if.o_lcd_rs, 0);
        wait_done(100);

        // Even toggles while busy: no second transfer
        wait_idle(100);
        start_xfer(8'h0C, 1'b0, 13);
        wait_en(1'b1);
        lcd_word[9] = ~lcd_word[9];
        tick();
        lcd_word[9] = ~lcd_word[9];
        d0 = done_cnt;
        wait_done(100);
        for (int i = 0; i < 30; i++) tick();
        check("even_toggle_dones", done_cnt - d0, 1);
        check("even_toggle_idle", lcd_if.o_busy, 0);

        // Power/backlight during WAIT
        start_xfer(8'h5A, 1'b1, 13);
        wait_en(1'b1);
        wait_en(1'b0);
        tick();
        tick();
        lcd_word[31:30] = 2'b11;
        check("on_not_comb", lcd_if.o_lcd_on, 0);
        tick();
        check("on_follow", lcd_if.o_lcd_on, 1);
        check("blon_follow", lcd_if.o_lcd_blon, 1);
        wait_done(100);

        // Mid-pulse reset, with toggle high at release
        wait_idle(100);
        start_xfer(8'h55, 1'b1, 13);
        wait_en(1'b1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        tick();
        check("midrst_en", lcd_if.o_lcd_en, 0);
        check("midrst_busy", lcd_if.o_busy, 1);
        check("midrst_data", lcd_if.o_lcd_data, 0);
        check("midrst_on", lcd_if.o_lcd_on, 0);
        tick();
        exp_q.delete();
        toggle = 1'b0;
        lcd_word = 32'h0;
        start_xfer(8'h33, 1'b0, 13);   // toggle now 1 vs cleared req_seen
        rst_n = 1'b1;
        mon_en = 1'b1;
        n = 0;
        while (lcd_if.o_busy && n < 50) begin
            n++;
            tick();
        end
        check("midrst_powerup_cycles", n, 10);
        wait_done(100);
        for (int i = 0; i < 20; i++) tick();
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
